// File: rtl/fp_sqrt_iter.sv
// fp_sqrt_iter
//   Iterative IEEE-754 square root, parametrised on exponent/fraction width.
//   One root bit per cycle (restoring digit-by-digit), subnormal inputs are
//   normalised, rounding is RNE or RZ per operand.
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   enable         synchronous soft clear when low (drops any in-flight op)
//   in_valid/in_ready/in_data/rnd_mode   operand handshake; rnd_mode 1 = RZ
//   out_valid/out_ready/out_data         result handshake, held until taken
//   is_nan, is_pinf, is_ninf             result flags (is_ninf tied low)
//   busy           unit is not idle
module fp_sqrt_iter #(
  parameter  int EXP_W = 5,
  parameter  int MAN_W = 10,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         rnd_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         is_nan,
  output logic         is_pinf,
  output logic         is_ninf,
  output logic         busy
);

  localparam int BIAS = (1 << (EXP_W-1)) - 1;
  localparam int EW   = EXP_W + $clog2(MAN_W+1) + 1;  // unbiased exponent incl. subnormal range
  localparam int RADW = 2*(MAN_W+2);                  // radicand: two bits per root bit
  localparam int RW   = MAN_W + 5;                    // partial remainder
  localparam int SW   = MAN_W + 2;                    // rounded significand with carry
  localparam int CW   = $clog2(MAN_W+2);

  typedef enum logic [2:0] {IDLE, NORM, ITER, ROUND, DONE} state_t;
  state_t state, state_n;

  logic [W-1:0]        opnd;
  logic                rz;
  logic [RADW-1:0]     rad;
  logic [RW-1:0]       rem;
  logic [MAN_W+1:0]    q;
  logic signed [EW-1:0] e;
  logic [CW-1:0]       cnt;

  function automatic int lzc(input logic [MAN_W-1:0] f);
    int  n;
    logic hit;
    n   = 0;
    hit = 1'b0;
    for (int i = MAN_W-1; i >= 0; i--) begin
      if (f[i]) hit = 1'b1;
      else if (!hit) n++;
    end
    return n;
  endfunction

  // ---------------- operand decode (from latched operand) ----------------
  logic             op_sign, exp_max, exp_zero, frac_zero, is_special;
  logic [EXP_W-1:0] op_exp;
  logic [MAN_W-1:0] op_frac;
  logic [W-1:0]     sp_data;
  logic             sp_nan, sp_pinf;

  always_comb begin
    op_sign    = opnd[W-1];
    op_exp     = opnd[W-2:MAN_W];
    op_frac    = opnd[MAN_W-1:0];
    exp_max    = &op_exp;
    exp_zero   = ~|op_exp;
    frac_zero  = ~|op_frac;
    is_special = exp_max | (exp_zero & frac_zero) | op_sign;

    sp_data = opnd;
    sp_nan  = 1'b0;
    sp_pinf = 1'b0;
    if (exp_max && !frac_zero) begin
      sp_nan = 1'b1;
    end else if (exp_zero && frac_zero) begin
      sp_nan = 1'b0;                      // +/-0 passes through, sign kept
    end else if (op_sign) begin
      sp_data = {1'b1, {EXP_W{1'b1}}, {{(MAN_W-1){1'b0}}, 1'b1}};
      sp_nan  = 1'b1;
    end else begin
      sp_pinf = 1'b1;
    end
  end

  // ---------------- normalisation ----------------
  int               lz, e_int;
  logic [MAN_W:0]   m_sub, m_norm;
  logic             e_odd;
  logic [RADW-1:0]  rad_init;
  logic signed [EW-1:0] e_adj;

  always_comb begin
    lz     = lzc(op_frac);
    m_sub  = {1'b0, op_frac};
    m_sub  = m_sub << (lz + 1);           // brings the leading one into the hidden position
    m_norm = exp_zero ? m_sub : {1'b1, op_frac};
    e_int  = exp_zero ? (-BIAS - lz) : (int'(op_exp) - BIAS);
    e_odd  = e_int[0];
    // Odd exponent folds one factor of 2 into the radicand so e/2 is exact.
    rad_init = e_odd ? {m_norm, 1'b0, {(MAN_W+2){1'b0}}}
                     : {1'b0, m_norm, {(MAN_W+2){1'b0}}};
    e_adj  = EW'(e_odd ? e_int - 1 : e_int);
  end

  // ---------------- one restoring root step ----------------
  logic [RW-1:0]    rem_sh, trial, rem_n;
  logic [MAN_W+1:0] q_n;

  always_comb begin
    rem_sh = {rem[RW-3:0], rad[RADW-1 -: 2]};
    trial  = {1'b0, q, 2'b01};
    if (rem_sh >= trial) begin
      rem_n = rem_sh - trial;
      q_n   = {q[MAN_W:0], 1'b1};
    end else begin
      rem_n = rem_sh;
      q_n   = {q[MAN_W:0], 1'b0};
    end
  end

  // ---------------- rounding ----------------
  // q = {1 integer bit, MAN_W fraction bits, guard}; sticky is a nonzero remainder.
  logic          inc, carry;
  logic [SW-1:0] sum;
  int            res_exp;
  logic [W-1:0]  res_data;

  always_comb begin
    inc      = !rz & q[0] & ((|rem) | q[1]);
    sum      = {1'b0, q[MAN_W+1:1]} + SW'(inc);
    carry    = sum[MAN_W+1];
    res_exp  = (int'(e) >>> 1) + BIAS + (carry ? 1 : 0);
    res_data = {1'b0, res_exp[EXP_W-1:0], carry ? {MAN_W{1'b0}} : sum[MAN_W-1:0]};
  end

  // ---------------- control ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = NORM;
      // Specials also pass through NORM so their result lands one cycle after acceptance.
      NORM:    state_n = is_special ? DONE : ITER;
      ITER:    if (cnt == CW'(MAN_W+1)) state_n = ROUND;
      ROUND:   state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (!enable) state_n = IDLE;
  end

  assign in_ready  = enable && (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign is_ninf   = 1'b0;

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd <= '0; rz <= 1'b0; rad <= '0; rem <= '0; q <= '0; e <= '0; cnt <= '0;
      out_data <= '0; is_nan <= 1'b0; is_pinf <= 1'b0;
    end else if (!enable) begin
      opnd <= '0; rz <= 1'b0; rad <= '0; rem <= '0; q <= '0; e <= '0; cnt <= '0;
      out_data <= '0; is_nan <= 1'b0; is_pinf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          opnd <= in_data;
          rz   <= rnd_mode;
        end
        NORM: if (is_special) begin
          out_data <= sp_data;
          is_nan   <= sp_nan;
          is_pinf  <= sp_pinf;
        end else begin
          rad <= rad_init;
          rem <= '0;
          q   <= '0;
          e   <= e_adj;
          cnt <= '0;
        end
        ITER: begin
          rad <= rad << 2;
          rem <= rem_n;
          q   <= q_n;
          cnt <= cnt + 1'b1;
        end
        ROUND: begin
          out_data <= res_data;
          is_nan   <= 1'b0;
          is_pinf  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// tb_fp_sqrt_iter
//   Random and directed stimulus against an FP16 and an FP32 instance; the
//   reference is an exact integer-sqrt model over the IEEE value.
module tb_fp_sqrt_iter;
  typedef longint unsigned u64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, enable, out_ready, rnd_mode;
  logic iv16, iv32;
  logic [15:0] id16;
  logic [31:0] id32;
  logic rdy16, ov16, nan16, pinf16, ninf16, busy16;
  logic rdy32, ov32, nan32, pinf32, ninf32, busy32;
  logic [15:0] od16;
  logic [31:0] od32;

  fp_sqrt_iter #(.EXP_W(5), .MAN_W(10)) u16 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(iv16), .in_ready(rdy16),
    .in_data(id16), .rnd_mode(rnd_mode), .out_valid(ov16), .out_ready(out_ready),
    .out_data(od16), .is_nan(nan16), .is_pinf(pinf16), .is_ninf(ninf16), .busy(busy16));

  fp_sqrt_iter #(.EXP_W(8), .MAN_W(23)) u32 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(iv32), .in_ready(rdy32),
    .in_data(id32), .rnd_mode(rnd_mode), .out_valid(ov32), .out_ready(out_ready),
    .out_data(od32), .is_nan(nan32), .is_pinf(pinf32), .is_ninf(ninf32), .busy(busy32));

  logic wsel;
  logic o_rdy, o_val, o_nan, o_pinf, o_ninf;
  u64   o_data;
  always_comb begin
    if (wsel) begin
      o_rdy = rdy32; o_val = ov32; o_nan = nan32; o_pinf = pinf32; o_ninf = ninf32;
      o_data = u64'(od32);
    end else begin
      o_rdy = rdy16; o_val = ov16; o_nan = nan16; o_pinf = pinf16; o_ninf = ninf16;
      o_data = u64'(od16);
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input u64 got, input u64 exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: exact value-level square root. The operand is turned into
  // sig * 2^(ex-mw) with sig normalised, ex made even, then the root is taken
  // with MAN_W+1 fraction bits by integer sqrt and rounded.
  function automatic void model(input u64 a, input int ew, input int mw, input bit rzm,
                                output u64 r, output bit nan, output bit pinf, output int lat);
    u64 emax, fmask, f, sig, x, rt, mant;
    int bias, ex, ee;
    bit s, sticky, guard;
    bias  = (1 << (ew-1)) - 1;
    emax  = (u64'(1) << ew) - 1;
    fmask = (u64'(1) << mw) - 1;
    s     = a[ew+mw];
    ee    = int'((a >> mw) & emax);
    f     = a & fmask;
    nan = 0; pinf = 0; lat = 1; r = a;
    if (u64'(ee) == emax && f != 0) nan = 1;
    else if (ee == 0 && f == 0) r = a;
    else if (s) begin
      r   = (u64'(1) << (ew+mw)) | (emax << mw) | u64'(1);
      nan = 1;
    end else if (u64'(ee) == emax) pinf = 1;
    else begin
      lat = mw + 4;
      sig = (ee == 0) ? f : (f | (u64'(1) << mw));
      ex  = (ee == 0) ? 1 - bias : ee - bias;
      while (sig < (u64'(1) << mw)) begin sig = sig << 1; ex--; end
      if (ex % 2 != 0) begin sig = sig << 1; ex--; end
      x  = sig << (mw + 2);
      rt = u64'(longint'($sqrt(real'(x))));
      while (rt * rt > x) rt--;
      while ((rt + 1) * (rt + 1) <= x) rt++;
      sticky = (rt * rt != x);
      guard  = rt[0];
      mant   = rt >> 1;
      if (!rzm && guard && (sticky || mant[0])) mant++;
      if ((mant >> (mw + 1)) != 0) begin mant = mant >> 1; ex += 2; end
      r = (u64'(ex/2 + bias) << mw) | (mant & fmask);
    end
  endfunction

  // One operation: hold<0 leaves the result pending in DONE.
  task automatic op(input bit wide, input u64 a, input bit rzm, input int hold,
                    input u64 want, input bit use_want);
    u64 er;
    bit en, ep;
    int lat, n;
    model(a, wide ? 8 : 5, wide ? 23 : 10, rzm, er, en, ep, lat);
    if (use_want) er = want;
    wsel = wide;
    @(negedge clk);
    chk("in_ready_idle", u64'(o_rdy), 1);
    rnd_mode = rzm;
    if (wide) begin iv32 = 1'b1; id32 = a[31:0]; end
    else      begin iv16 = 1'b1; id16 = a[15:0]; end
    @(posedge clk); #1;
    iv16 = 1'b0; iv32 = 1'b0;
    id16 = 16'($urandom); id32 = $urandom; rnd_mode = 1'($urandom);
    n = 0;
    while (!o_val && n < 100) begin @(posedge clk); #1; n++; end
    chk($sformatf("latency[%h]", a), u64'(n), u64'(lat));
    chk($sformatf("data[%h rz=%0d]", a, rzm), o_data, er);
    chk("is_nan", u64'(o_nan), u64'(en));
    chk("is_pinf", u64'(o_pinf), u64'(ep));
    chk("is_ninf", u64'(o_ninf), 0);
    if (hold < 0) return;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", u64'(o_val), 1);
      chk("hold_data", o_data, er);
      chk("hold_in_ready", u64'(o_rdy), 0);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drop_after_hs", u64'(o_val), 0);
    chk("in_ready_after_hs", u64'(o_rdy), 1);
  endtask

  u64 dv[15] = '{64'h4400, 64'h3C00, 64'h3400, 64'h4200, 64'h4200, 64'h4000, 64'h4000,
                 64'h0001, 64'h0200, 64'h7C01, 64'h7C00, 64'hFC00, 64'hBC00, 64'h8000, 64'h0000};
  bit drz[15] = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  u64 dw[15] = '{64'h4000, 64'h3C00, 64'h3800, 64'h3EEE, 64'h3EED, 64'h3DA8, 64'h3DA8,
                 64'h0C00, 64'h1DA8, 64'h7C01, 64'h7C00, 64'hFC01, 64'hFC01, 64'h8000, 64'h0000};

  initial begin
    bit seen;
    u64 a;
    rst_n = 1'b0; enable = 1'b1; out_ready = 1'b0; rnd_mode = 1'b0; wsel = 1'b0;
    iv16 = 1'b0; iv32 = 1'b0; id16 = '0; id32 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", u64'(rdy16), 1);
    chk("rst_out_valid", u64'(ov16), 0);
    chk("rst_out_data", u64'(od16), 0);
    chk("rst_busy", u64'(busy16), 0);
    chk("rst_flags", u64'({nan16, pinf16, ninf16}), 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 15; i++) op(0, dv[i], drz[i], 0, dw[i], 1);

    // backpressure
    op(0, 64'h4200, 0, 5, 64'h3EEE, 1);

    // soft abort during iteration
    wsel = 1'b0;
    @(negedge clk); iv16 = 1'b1; id16 = 16'h4400; rnd_mode = 1'b0;
    @(posedge clk); #1 iv16 = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk) enable = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", u64'(busy16), 0);
    chk("abort_valid", u64'(ov16), 0);
    chk("abort_in_ready", u64'(rdy16), 0);
    chk("abort_data", u64'(od16), 0);
    @(negedge clk) enable = 1'b1;
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (ov16) seen = 1; end
    chk("abort_no_result", u64'(seen), 0);
    op(0, 64'h4400, 0, 0, 64'h4000, 1);

    // async reset with a result pending
    op(0, 64'h7C00, 0, -1, 64'h7C00, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", u64'(ov16), 0);
    chk("arst_data", u64'(od16), 0);
    chk("arst_pinf", u64'(pinf16), 0);
    @(negedge clk) rst_n = 1'b1;

    // async reset mid-iteration
    @(negedge clk); iv16 = 1'b1; id16 = 16'h4200;
    @(posedge clk); #1 iv16 = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_iter_busy", u64'(busy16), 0);
    chk("arst_iter_valid", u64'(ov16), 0);
    @(negedge clk) rst_n = 1'b1;
    op(0, 64'h3C00, 0, 0, 64'h3C00, 1);

    // FP32 instance
    op(1, 64'h40000000, 0, 0, 64'h3FB504F3, 1);
    op(1, 64'h40800000, 1, 1, 64'h40000000, 1);

    for (int i = 0; i < 150; i++) begin
      a = u64'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) != 0) a[15] = 1'b0;
      op(0, a, 1'($urandom), int'($urandom_range(0, 2)), 0, 0);
    end
    for (int i = 0; i < 30; i++) begin
      a = u64'($urandom);
      if ($urandom_range(0, 3) != 0) a[31] = 1'b0;
      op(1, a, 1'($urandom), int'($urandom_range(0, 1)), 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
